// File: rtl/bus_mem_slave.sv
// Burst-capable memory slave for the shared system bus: address phase on ack,
// LATENCY wait cycles, then incrementing or wrapping data beats.
`timescale 1ns/1ps
module bus_mem_slave #(
  parameter int BUS_WIDTH  = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ack,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out
);

  localparam int IW = $clog2(DEPTH);
  localparam int AW = IW + 1;
  localparam int LW = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DATA,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [AW-1:0]        start_addr;
  logic                 we_r;
  logic                 wrap_r;
  logic                 err_r;
  logic [4:0]           beats_r;
  logic [4:0]           beat_cnt;
  logic [LW-1:0]        lat_cnt;
  logic                 lat_last;
  logic                 beat_last;
  logic [AW-1:0]        offset;
  logic [AW-1:0]        mask;
  logic [AW-1:0]        wrap_addr;
  logic [AW-1:0]        beat_addr;
  logic [IW-1:0]        idx;
  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic                 unused_bits;

  function automatic logic [4:0] burst_beats(input logic [2:0] code);
    case (code)
      3'b001:  return 5'd2;
      3'b010:  return 5'd4;
      3'b011:  return 5'd8;
      3'b100:  return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  assign lat_last  = (lat_cnt == LW'(LATENCY - 1));
  assign beat_last = (beat_cnt == beats_r - 5'd1);

  // Wrapping keeps the upper address bits of the start and cycles the low
  // log2(beats) bits; the final index is the address reduced mod DEPTH.
  assign offset    = start_addr + AW'(beat_cnt);
  assign mask      = AW'(beats_r - 5'd1);
  assign wrap_addr = (start_addr & ~mask) | (offset & mask);
  assign beat_addr = wrap_r ? wrap_addr : offset;
  assign idx       = beat_addr[IW-1:0];

  assign unused_bits = ^{ctrl_in, beat_addr[AW-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr <= '0;
      we_r       <= 1'b0;
      wrap_r     <= 1'b0;
      err_r      <= 1'b0;
      beats_r    <= 5'd0;
      beat_cnt   <= 5'd0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ack) begin
            start_addr <= bus_in[AW-1:0];
            we_r       <= ctrl_in[1];
            beats_r    <= burst_beats(ctrl_in[4:2]);
            wrap_r     <= ctrl_in[5];
            err_r      <= (bus_in >= BUS_WIDTH'(DEPTH));
            beat_cnt   <= 5'd0;
            lat_cnt    <= '0;
          end
        end
        WAIT:    lat_cnt <= lat_cnt + LW'(1);
        DATA:    beat_cnt <= beat_cnt + 5'd1;
        FINISH: begin
          if (!ack) begin
            err_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory is never cleared; writes are blocked in reset and error transactions.
  always_ff @(posedge clk) begin
    if (!rst && state == DATA && we_r && !err_r) begin
      mem[idx] <= bus_in;
    end
  end

  always_comb begin
    next_state = state;
    bus_out    = '0;
    ctrl_out   = '0;
    case (state)
      IDLE: begin
        if (ack) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        ctrl_out[0] = !lat_last;
        if (lat_last) begin
          next_state = DATA;
        end
      end
      DATA: begin
        ctrl_out[1] = 1'b1;
        if (!we_r && !err_r) begin
          bus_out = mem[idx];
        end
        if (beat_last) begin
          next_state = FINISH;
        end
      end
      FINISH: begin
        if (!ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    ctrl_out[2] = err_r && (state != IDLE);
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: the driver queues expected strobe cycles,
// an independent monitor pops and compares whenever ctrl_out shows activity.
`timescale 1ns/1ps
module tb_bus_mem_slave;

  localparam int BW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ack;
  logic [BW-1:0] bus_in;
  logic [CW-1:0] ctrl_in;
  logic [BW-1:0] bus_out;
  logic [CW-1:0] ctrl_out;

  typedef struct {
    int            cyc;
    logic [CW-1:0] ctrl;
    logic [BW-1:0] data;
    string         name;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [BW-1:0] beat_data [16];
  int            cyc      = 0;
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            mon_en   = 1'b0;

  bus_mem_slave #(
    .BUS_WIDTH(BW),
    .CTRL_WIDTH(CW),
    .DEPTH(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ack(ack),
    .bus_in(bus_in),
    .ctrl_in(ctrl_in),
    .bus_out(bus_out),
    .ctrl_out(ctrl_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ctrl_out != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_strobe: got ctrl_out 0x%0h at cycle %0d, expected no activity",
                   ctrl_out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.cyc));
          check_output({mon_e.name, "_ctrl"}, 64'(ctrl_out), 64'(mon_e.ctrl));
          check_output({mon_e.name, "_data"}, 64'(bus_out), 64'(mon_e.data));
        end
      end else begin
        check_output("quiet_bus_out", 64'(bus_out), 64'd0);
      end
    end
  end

  // nb and err are hand-supplied; drop is the first cycle with ack low,
  // abort (>0) is the cycle in which rst is pulsed.
  task automatic apply_stimulus(input string name, input logic [BW-1:0] addr, input logic [2:0] code,
                                input logic we, input logic wrap, input int nb, input logic err,
                                input int drop, input int abort);
    int            t0;
    int            f0;
    int            fe;
    int            last;
    exp_t          x;
    logic [CW-1:0] c_exp;
    @(negedge clk);
    t0   = cyc + 1;
    f0   = LAT + 1 + nb;
    fe   = (drop > f0) ? drop : f0;
    last = (abort > 0) ? abort : fe;
    for (int c = 1; c <= last; c++) begin
      c_exp    = '0;
      c_exp[2] = err;
      if (c < LAT) c_exp[0] = 1'b1;
      else if (c > LAT && c <= LAT + nb) c_exp[1] = 1'b1;
      x.cyc  = t0 + c - 1;
      x.ctrl = c_exp;
      x.data = (c_exp[1] && !we && !err) ? beat_data[c-LAT-1] : '0;
      x.name = $sformatf("%s_c%0d", name, c);
      if (c_exp != '0) exp_q.push_back(x);
    end
    ack     = 1'b1;
    rst     = 1'b0;
    bus_in  = addr;
    ctrl_in = {1'b1, 1'b0, wrap, code, we, 1'b1};
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      ack     = (c < drop);
      rst     = (c == abort);
      ctrl_in = 8'hFF;
      bus_in  = (we && c > LAT && c <= LAT + nb) ? beat_data[c-LAT-1] : (32'hF00D_0000 | 32'(c));
    end
    @(negedge clk);
    ack     = 1'b0;
    rst     = 1'b0;
    bus_in  = '0;
    ctrl_in = '0;
    if (abort > 0) begin
      check_output({name, "_post_reset_ctrl"}, 64'(ctrl_out), 64'd0);
      check_output({name, "_post_reset_bus"}, 64'(bus_out), 64'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    ack     = 1'b0;
    bus_in  = '0;
    ctrl_in = '0;
    repeat (3) @(negedge clk);
    check_output("reset_ctrl_out", 64'(ctrl_out), 64'd0);
    check_output("reset_bus_out", 64'(bus_out), 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) beat_data[i] = 32'h100 + 32'(i);
    apply_stimulus("fill", 32'd0, 3'b100, 1'b1, 1'b0, 16, 1'b0, 2, -1);

    beat_data[0] = 32'hDEAD_BEEF;
    apply_stimulus("wr_single", 32'd3, 3'b000, 1'b1, 1'b0, 1, 1'b0, 1, -1);
    apply_stimulus("rd_single", 32'd3, 3'b000, 1'b0, 1'b0, 1, 1'b0, 8, -1);

    for (int i = 0; i < 4; i++) beat_data[i] = 32'hA0 + 32'(i);
    apply_stimulus("wr_inc4", 32'd2, 3'b010, 1'b1, 1'b0, 4, 1'b0, 3, -1);
    apply_stimulus("rd_inc4", 32'd2, 3'b010, 1'b0, 1'b0, 4, 1'b0, 6, -1);

    beat_data[0] = 32'h44; beat_data[1] = 32'h55; beat_data[2] = 32'h66; beat_data[3] = 32'h77;
    apply_stimulus("wr_4to7", 32'd4, 3'b010, 1'b1, 1'b0, 4, 1'b0, 1, -1);
    beat_data[0] = 32'h66; beat_data[1] = 32'h77; beat_data[2] = 32'h44; beat_data[3] = 32'h55;
    apply_stimulus("rd_wrap4", 32'd6, 3'b010, 1'b0, 1'b1, 4, 1'b0, 1, -1);

    for (int i = 0; i < 8; i++) beat_data[i] = 32'(i + 1);
    apply_stimulus("wr_inc8", 32'd12, 3'b011, 1'b1, 1'b0, 8, 1'b0, 1, -1);

    for (int i = 0; i < 4; i++) beat_data[i] = 32'hBAD0 + 32'(i);
    apply_stimulus("err_wr", 32'd20, 3'b010, 1'b1, 1'b0, 4, 1'b1, 11, -1);

    beat_data[0]  = 32'h5;   beat_data[1]  = 32'h6;   beat_data[2]  = 32'h7;   beat_data[3]  = 32'h8;
    beat_data[4]  = 32'h44;  beat_data[5]  = 32'h55;  beat_data[6]  = 32'h66;  beat_data[7]  = 32'h77;
    beat_data[8]  = 32'h108; beat_data[9]  = 32'h109; beat_data[10] = 32'h10A; beat_data[11] = 32'h10B;
    beat_data[12] = 32'h1;   beat_data[13] = 32'h2;   beat_data[14] = 32'h3;   beat_data[15] = 32'h4;
    apply_stimulus("rd_all", 32'd0, 3'b100, 1'b0, 1'b0, 16, 1'b0, 1, -1);

    for (int i = 0; i < 4; i++) beat_data[i] = 32'hC0 + 32'(i);
    apply_stimulus("wr_abort", 32'd8, 3'b010, 1'b1, 1'b0, 4, 1'b0, 20, 6);

    beat_data[0] = 32'hC0; beat_data[1] = 32'h109; beat_data[2] = 32'h10A; beat_data[3] = 32'h10B;
    apply_stimulus("rd_after_abort", 32'd8, 3'b010, 1'b0, 1'b0, 4, 1'b0, 1, -1);

    beat_data[0] = 32'h109; beat_data[1] = 32'hC0;
    apply_stimulus("rd_wrap2", 32'd9, 3'b001, 1'b0, 1'b1, 2, 1'b0, 1, -1);

    beat_data[0] = 32'h4;
    apply_stimulus("rd_code101", 32'd15, 3'b101, 1'b0, 1'b0, 1, 1'b0, 1, -1);

    beat_data[0] = 32'h2;   beat_data[1] = 32'h3;   beat_data[2] = 32'h4;   beat_data[3] = 32'hC0;
    beat_data[4] = 32'h109; beat_data[5] = 32'h10A; beat_data[6] = 32'h10B; beat_data[7] = 32'h1;
    apply_stimulus("rd_wrap8", 32'd13, 3'b011, 1'b0, 1'b1, 8, 1'b0, 1, -1);

    apply_stimulus("err_rd_high", 32'h8000_0003, 3'b000, 1'b0, 1'b0, 1, 1'b1, 1, -1);

    repeat (4) @(negedge clk);
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
